aes_masked_job_arbiter: RTL

Round-robin job scheduler that shares one masked AES-128 encryption core (`aes128_core_masked`) among `NUM_REQ` requesters. It accepts one job at a time and draws a fresh mask from an internal LFSR for each job. It sequences the core's start/done protocol, guards against a hung core with a watchdog, and returns the ciphertext tagged with the requester ID over a response handshake with backpressure. It sits between the requester fabric and the core instance.

---
 rtl/aes_masked_job_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/aes_masked_job_arbiter.sv
// Round-robin job scheduler that shares one masked AES-128 core among NUM_REQ requesters.
// One job in flight at a time; each job gets a fresh LFSR mask and a watchdog on core_done.
module aes_masked_job_arbiter #(
  parameter int          NUM_REQ   = 4,
  parameter int          TIMEOUT   = 300,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*128-1:0]       req_plaintext,
  input  logic [NUM_REQ*128-1:0]       req_key,
  input  logic                         fault_arm,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic [127:0]                 rsp_data,
  output logic                         rsp_error,
  output logic                         core_start,
  output logic [127:0]                 core_plaintext,
  output logic [127:0]                 core_key,
  output logic [127:0]                 core_mask,
  output logic                         core_fault_inject,
  input  logic [127:0]                 core_ciphertext,
  input  logic                         core_done,
  input  logic                         core_busy,
  output logic [15:0]                  jobs_done
);

  localparam int          IDW     = $clog2(NUM_REQ);
  localparam int unsigned NREQ    = NUM_REQ;
  localparam int          WDW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [31:0] SEED    = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
  localparam logic [31:0] TAPS    = 32'h8020_0003;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [31:0]    lfsr_q, lfsr_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic [127:0]   pt_q, pt_d;
  logic [127:0]   key_q, key_d;
  logic [127:0]   mask_q, mask_d;
  logic           fault_q, fault_d;
  logic [127:0]   data_q, data_d;
  logic           err_q, err_d;
  logic [15:0]    jobs_q, jobs_d;

  logic           grant_vld;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] cand;
  logic           accept;

  // First asserted requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDW'((32'(rr_ptr_q) + k) % NREQ);
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign accept = (state_q == IDLE) && grant_vld;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    lfsr_d = (lfsr_q == '0) ? 32'h1 : ((lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0));
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    id_d       = id_q;
    wd_d       = wd_q;
    pt_d       = pt_q;
    key_d      = key_q;
    mask_d     = mask_q;
    fault_d    = fault_q;
    data_d     = data_q;
    err_d      = err_q;
    jobs_d     = jobs_q;
    core_start = 1'b0;
    rsp_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          pt_d     = req_plaintext[128*32'(grant_idx) +: 128];
          key_d    = req_key[128*32'(grant_idx) +: 128];
          mask_d   = {4{lfsr_q}};
          fault_d  = fault_arm;
          id_d     = grant_idx;
          rr_ptr_d = (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
          state_d  = START;
        end
      end
      START: begin
        // A timed-out job may still occupy the core; wait for it to drain.
        if (!core_busy) begin
          core_start = 1'b1;
          wd_d       = '0;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (core_done) begin
          data_d  = core_ciphertext;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (wd_q == WD_LAST) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          jobs_d  = jobs_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      lfsr_q   <= SEED;
      wd_q     <= '0;
      pt_q     <= '0;
      key_q    <= '0;
      mask_q   <= '0;
      fault_q  <= 1'b0;
      data_q   <= '0;
      err_q    <= 1'b0;
      jobs_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      lfsr_q   <= lfsr_d;
      wd_q     <= wd_d;
      pt_q     <= pt_d;
      key_q    <= key_d;
      mask_q   <= mask_d;
      fault_q  <= fault_d;
      data_q   <= data_d;
      err_q    <= err_d;
      jobs_q   <= jobs_d;
    end
  end

  assign rsp_id            = id_q;
  assign rsp_data          = data_q;
  assign rsp_error         = err_q;
  assign core_plaintext    = pt_q;
  assign core_key          = key_q;
  assign core_mask         = mask_q;
  assign core_fault_inject = fault_q;
  assign jobs_done         = jobs_q;

endmodule
